proto245_regbridge: RTL

// - Register-access bridge downstream of the FT245 protocol master's RXFIFO and upstream of its TXFIFO.
// - Parses host command frames read from RXFIFO and performs single register reads/writes on a req/ack bus.
// - Pushes a status/response frame into TXFIFO.
// - Lives entirely in the fifo_clk domain.

---
 rtl/proto245_pkg.sv | 22 ++
 rtl/proto245_regbridge.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/proto245_pkg.sv
// Shared constants and state type for the FT245 register bridge.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package proto245_pkg;

  localparam logic [7:0] CMD_WR       = 8'h01;
  localparam logic [7:0] CMD_RD       = 8'h02;
  localparam int         STAT_ERR_BIT = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX_ADDR,
    ST_RX_DATA,
    ST_BUS,
    ST_TX_RESP
  } regbridge_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/proto245_regbridge.sv
// Parses host frames from RXFIFO into one register access and returns a status/data frame to TXFIFO.
// Latency: request 1 cycle after last frame byte; first response byte 1 cycle after bus access ends.
// Backpressure: one RX read outstanding at most; TX bytes hold while txfifo_full, no RX fetch during BUS/TX_RESP.
module proto245_regbridge
  import proto245_pkg::*;
#(
  parameter int ADDR_BYTES    = 2,
  parameter int REG_BYTES     = 4,
  parameter int TIMEOUT_TICKS = 255
) (
  input  logic                    fifo_clk,
  input  logic                    fifo_rstn,
  output logic                    rxfifo_rd,
  input  logic [7:0]              rxfifo_data,
  input  logic                    rxfifo_valid,
  input  logic                    rxfifo_empty,
  output logic [7:0]              txfifo_data,
  output logic                    txfifo_wr,
  input  logic                    txfifo_full,
  output logic [8*ADDR_BYTES-1:0] reg_addr,
  output logic [8*REG_BYTES-1:0]  reg_wdata,
  output logic                    reg_wen,
  output logic                    reg_ren,
  input  logic [8*REG_BYTES-1:0]  reg_rdata,
  input  logic                    reg_ack,
  output logic                    busy,
  output logic [7:0]              err_cnt
);

  localparam int AW  = 8 * ADDR_BYTES;
  localparam int DW  = 8 * REG_BYTES;
  localparam int RW  = 8 * (REG_BYTES + 1);
  localparam int BCW = $clog2(max2(ADDR_BYTES, REG_BYTES) + 1);
  localparam int TCW = $clog2(TIMEOUT_TICKS + 1);
  localparam int TXW = $clog2(REG_BYTES + 2);

  regbridge_state_t r_state;
  logic             r_run;
  logic             r_rd_pending;
  logic             r_is_rd;
  logic [BCW-1:0]   r_byte_cnt;
  logic [TCW-1:0]   r_tmo_cnt;
  logic [AW-1:0]    r_addr;
  logic [DW-1:0]    r_wdata;
  logic             r_wen;
  logic             r_ren;
  logic [RW-1:0]    r_resp;
  logic [TXW-1:0]   r_tx_left;
  logic [7:0]       r_err_cnt;

  logic             w_need_byte;
  logic             w_byte_vld;
  logic             w_is_cmd;
  logic             w_timeout;
  logic             w_err_inc;
  logic [7:0]       w_status;

  // r_run keeps the read strobe quiet while reset is held and for one cycle after release
  assign w_need_byte = r_run && (r_state == ST_IDLE || r_state == ST_RX_ADDR || r_state == ST_RX_DATA);
  assign w_byte_vld  = rxfifo_valid && r_rd_pending;
  assign w_is_cmd    = (rxfifo_data == CMD_WR) || (rxfifo_data == CMD_RD);
  assign w_timeout   = (r_tmo_cnt == TCW'(TIMEOUT_TICKS)) && !reg_ack;
  assign w_err_inc   = (r_state == ST_IDLE && w_byte_vld && !w_is_cmd) || (r_state == ST_BUS && w_timeout);

  assign rxfifo_rd   = w_need_byte && !r_rd_pending && !rxfifo_empty;
  assign txfifo_wr   = (r_state == ST_TX_RESP) && !txfifo_full;
  assign txfifo_data = r_resp[RW-1 -: 8];
  assign reg_addr    = r_addr;
  assign reg_wdata   = r_wdata;
  assign reg_wen     = r_wen;
  assign reg_ren     = r_ren;
  assign busy        = (r_state != ST_IDLE);
  assign err_cnt     = r_err_cnt;

  // Status byte echoes the opcode; the error bit is set when the access ended without an ack
  always_comb begin
    w_status               = r_is_rd ? CMD_RD : CMD_WR;
    w_status[STAT_ERR_BIT] = !reg_ack;
  end

  // Single outstanding RX read: set on the strobe, cleared when its data returns
  always_ff @(posedge fifo_clk or negedge fifo_rstn) begin
    if (!fifo_rstn) begin
      r_rd_pending <= 1'b0;
    end else if (rxfifo_rd) begin
      r_rd_pending <= 1'b1;
    end else if (rxfifo_valid) begin
      r_rd_pending <= 1'b0;
    end
  end

  // Frame parser, bus access, response emitter and saturating error counter
  always_ff @(posedge fifo_clk or negedge fifo_rstn) begin
    if (!fifo_rstn) begin
      r_state    <= ST_IDLE;
      r_run      <= 1'b0;
      r_is_rd    <= 1'b0;
      r_byte_cnt <= '0;
      r_tmo_cnt  <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wen      <= 1'b0;
      r_ren      <= 1'b0;
      r_resp     <= '0;
      r_tx_left  <= '0;
      r_err_cnt  <= '0;
    end else begin
      r_run <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_byte_vld && w_is_cmd) begin
            r_is_rd    <= (rxfifo_data == CMD_RD);
            r_byte_cnt <= '0;
            r_state    <= ST_RX_ADDR;
          end
        end
        ST_RX_ADDR: begin
          if (w_byte_vld) begin
            r_addr <= (r_addr << 8) | AW'(rxfifo_data);
            if (r_byte_cnt == BCW'(ADDR_BYTES - 1)) begin
              r_byte_cnt <= '0;
              if (r_is_rd) begin
                r_ren     <= 1'b1;
                r_tmo_cnt <= '0;
                r_state   <= ST_BUS;
              end else begin
                r_state <= ST_RX_DATA;
              end
            end else begin
              r_byte_cnt <= r_byte_cnt + 1'b1;
            end
          end
        end
        ST_RX_DATA: begin
          if (w_byte_vld) begin
            r_wdata <= (r_wdata << 8) | DW'(rxfifo_data);
            if (r_byte_cnt == BCW'(REG_BYTES - 1)) begin
              r_byte_cnt <= '0;
              r_wen      <= 1'b1;
              r_tmo_cnt  <= '0;
              r_state    <= ST_BUS;
            end else begin
              r_byte_cnt <= r_byte_cnt + 1'b1;
            end
          end
        end
        ST_BUS: begin
          // an ack on the final wait cycle still wins over the timeout
          if (reg_ack || w_timeout) begin
            r_wen     <= 1'b0;
            r_ren     <= 1'b0;
            r_resp    <= {w_status, (reg_ack ? reg_rdata : {DW{1'b1}})};
            r_tx_left <= r_is_rd ? TXW'(REG_BYTES + 1) : TXW'(1);
            r_state   <= ST_TX_RESP;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        ST_TX_RESP: begin
          if (!txfifo_full) begin
            r_resp    <= r_resp << 8;
            r_tx_left <= r_tx_left - 1'b1;
            if (r_tx_left == TXW'(1)) begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      if (w_err_inc && r_err_cnt != 8'hFF) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

endmodule
